// File: rtl/round_sat.sv
// round_sat: drops NBITS LSBs from a signed or unsigned fixed-point stream.
// It rounds (truncate, half-up or half-to-even), then saturates or wraps the
// narrowed DIN-NBITS result. The stage is a registered valid/ready stage with
// a skid buffer, and it keeps a sticky-saturating count of overflowing words.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   din_valid   input word valid
//   din_ready   stage can accept a word (depends only on skid occupancy)
//   din_data    input word, DIN bits
//   dout_valid  output word valid
//   dout_ready  downstream accepts the output word
//   dout_data   rounded, narrowed result, DIN-NBITS bits
//   ovf_clr     synchronous clear of ovf_cnt
//   ovf_cnt     count of accepted words that overflowed, saturating
module round_sat #(
  parameter int DIN    = 16,
  parameter int NBITS  = 4,
  parameter int SIGNED = 1,
  parameter int MODE   = 2,
  parameter int SAT    = 1,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DIN-1:0]        din_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DIN-NBITS-1:0]  dout_data,
  input  logic                  ovf_clr,
  output logic [CNT_W-1:0]      ovf_cnt
);

  localparam int DOUT = DIN - NBITS;

  generate
    if (NBITS < 1 || NBITS >= DIN || MODE < 0 || MODE > 2) begin : g_param_check
      $error("round_sat: illegal parameters (need 1 <= NBITS < DIN and MODE in 0..2)");
    end
  endgenerate

  localparam logic [NBITS-1:0] HALF     = NBITS'(64'd1 << (NBITS - 1));
  localparam logic [DOUT-1:0]  ALL_ONES = '1;
  localparam logic [DOUT-1:0]  MAX      = (SIGNED != 0) ? (ALL_ONES >> 1) : ALL_ONES;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [DOUT:0]      q;
  logic [DOUT:0]      r;
  logic [NBITS-1:0]   frac;
  logic               inc;
  logic               ovf;
  logic [DOUT-1:0]    result;

  logic               main_valid;
  logic [DOUT-1:0]    main_data;
  logic               skid_valid;
  logic [DOUT-1:0]    skid_data;
  logic               accept;
  logic               drain;

  // The quotient is kept one bit wider than the output so the rounding
  // increment can never be lost; the extra top bit is the sign extension
  // for signed data and zero for unsigned data.
  always_comb begin
    q    = {1'((SIGNED != 0) && din_data[DIN-1]), din_data[DIN-1:NBITS]};
    frac = din_data[NBITS-1:0];
    case (MODE)
      1:       inc = (frac >= HALF);
      2:       inc = (frac > HALF) || ((frac == HALF) && q[0]);
      default: inc = 1'b0;
    endcase
    r = q + {{DOUT{1'b0}}, inc};
    // Rounding only ever moves upward, so the sole overflow case is
    // exceeding the positive maximum: for signed data that is r landing
    // exactly on 2^(DOUT-1), for unsigned data a carry into the extra bit.
    if (SIGNED != 0) begin
      ovf = (r[DOUT:DOUT-1] == 2'b01);
    end else begin
      ovf = r[DOUT];
    end
    result = ((SAT != 0) && ovf) ? MAX : r[DOUT-1:0];
  end

  assign accept     = din_valid && din_ready;
  assign drain      = main_valid && dout_ready;
  assign din_ready  = !skid_valid;
  assign dout_valid = main_valid;
  assign dout_data  = main_data;

  // Main/skid buffer. The skid register only fills while main is stalled,
  // and since din_ready is low whenever skid is occupied, a refill from skid
  // and a new accept can never compete for main in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (drain) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_data <= result;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid) begin
          main_data  <= result;
          main_valid <= 1'b1;
        end else begin
          skid_data  <= result;
          skid_valid <= 1'b1;
        end
      end
    end
  end

  // Overflow counter: an overflowing accept wins over a simultaneous clear
  // (the count restarts at 1) so no event is ever lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (accept && ovf) begin
      if (ovf_clr) begin
        ovf_cnt <= CNT_W'(1);
      end else if (ovf_cnt != CNT_MAX) begin
        ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_round_sat.sv
// tb_round_sat: table-driven scoreboard bench for round_sat.
// Five instances share one input stream and handshake. They differ only in
// rounding mode, saturation and signedness, so every accepted word is checked
// against five hand-derived results. Expected records are queued when a word
// is accepted and popped when the main instance hands out a word.
module tb_round_sat;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic [15:0] din_data;
  logic        dout_ready;
  logic        ovf_clr;

  logic        din_ready_m2, din_ready_m1, din_ready_m0, din_ready_wr, din_ready_un;
  logic        dout_valid_m2, dout_valid_m1, dout_valid_m0, dout_valid_wr, dout_valid_un;
  logic [11:0] dout_data_m2, dout_data_m1, dout_data_m0, dout_data_wr, dout_data_un;
  logic [1:0]  ovf_cnt_m2, ovf_cnt_m1, ovf_cnt_m0, ovf_cnt_wr, ovf_cnt_un;

  typedef struct {
    logic [15:0] din;
    logic [11:0] m2;
    logic [11:0] m1;
    logic [11:0] m0;
    logic [11:0] wr;
    logic [11:0] un;
    bit          chk_lat;
    bit          chk_gap;
    int          cyc;
  } vec_t;

  vec_t tbl[10];
  vec_t sb[$];
  vec_t cur_rec;
  int   checks;
  int   errors;
  int   ncyc;
  int   last_pop;

  // Signed, half-to-even, saturating
  round_sat #(.DIN(16), .NBITS(4), .SIGNED(1), .MODE(2), .SAT(1), .CNT_W(2)) u_m2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready_m2),
    .din_data(din_data), .dout_valid(dout_valid_m2), .dout_ready(dout_ready),
    .dout_data(dout_data_m2), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt_m2));

  // Signed, half-up, saturating
  round_sat #(.DIN(16), .NBITS(4), .SIGNED(1), .MODE(1), .SAT(1), .CNT_W(2)) u_m1 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready_m1),
    .din_data(din_data), .dout_valid(dout_valid_m1), .dout_ready(dout_ready),
    .dout_data(dout_data_m1), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt_m1));

  // Signed, truncate, saturating
  round_sat #(.DIN(16), .NBITS(4), .SIGNED(1), .MODE(0), .SAT(1), .CNT_W(2)) u_m0 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready_m0),
    .din_data(din_data), .dout_valid(dout_valid_m0), .dout_ready(dout_ready),
    .dout_data(dout_data_m0), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt_m0));

  // Signed, half-to-even, wrapping
  round_sat #(.DIN(16), .NBITS(4), .SIGNED(1), .MODE(2), .SAT(0), .CNT_W(2)) u_wr (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready_wr),
    .din_data(din_data), .dout_valid(dout_valid_wr), .dout_ready(dout_ready),
    .dout_data(dout_data_wr), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt_wr));

  // Unsigned, half-up, saturating
  round_sat #(.DIN(16), .NBITS(4), .SIGNED(0), .MODE(1), .SAT(1), .CNT_W(2)) u_un (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready_un),
    .din_data(din_data), .dout_valid(dout_valid_un), .dout_ready(dout_ready),
    .dout_data(dout_data_un), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt_un));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [15:0] d, input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] w, input logic [11:0] u,
                              input bit lat, input bit gap);
    vec_t v;
    v.din = d; v.m2 = a; v.m1 = b; v.m0 = c; v.wr = w; v.un = u;
    v.chk_lat = lat; v.chk_gap = gap; v.cyc = 0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one word and return #1 after the edge on which it was accepted.
  task automatic applyStimulus(input vec_t v);
    bit ok;
    cur_rec   = v;
    din_data  = v.din;
    din_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (din_ready_m2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got din_ready=0 expected 1 for din %0h", v.din);
      din_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic clearCounters();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
  endtask

  // Scoreboard: pop and compare on every output handshake, push on every
  // input handshake. Both are sampled mid-cycle, where all signals are stable.
  always @(negedge clk) begin
    vec_t r;
    ncyc++;
    if (rst && dout_valid_m2 && dout_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got %0h expected no word", dout_data_m2);
      end else begin
        r = sb.pop_front();
        checkOutput("dout_m2", 64'(dout_data_m2), 64'(r.m2));
        checkOutput("dout_m1", 64'(dout_data_m1), 64'(r.m1));
        checkOutput("dout_m0", 64'(dout_data_m0), 64'(r.m0));
        checkOutput("dout_wr", 64'(dout_data_wr), 64'(r.wr));
        checkOutput("dout_un", 64'(dout_data_un), 64'(r.un));
        if (r.chk_lat) checkOutput("latency", 64'(ncyc - r.cyc), 64'd1);
        if (r.chk_gap) checkOutput("gap", 64'(ncyc - last_pop), 64'd1);
        last_pop = ncyc;
      end
    end
    if (rst && din_valid && din_ready_m2) begin
      r = cur_rec;
      r.cyc = ncyc;
      sb.push_back(r);
    end
  end

  initial begin
    vec_t a, b, c, d, sat_w, uns_w;
    int   exp_cnt;
    checks = 0; errors = 0; ncyc = 0; last_pop = 0;
    din_valid = 1'b0; din_data = '0; dout_ready = 1'b1; ovf_clr = 1'b0;
    cur_rec = mk(16'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0, 1'b0);

    //               din       m2      m1      m0      wr      un
    tbl[0] = mk(16'h0018, 12'h002, 12'h002, 12'h001, 12'h002, 12'h002, 1'b1, 1'b0);
    tbl[1] = mk(16'h0028, 12'h002, 12'h003, 12'h002, 12'h002, 12'h003, 1'b1, 1'b0);
    tbl[2] = mk(16'h0029, 12'h003, 12'h003, 12'h002, 12'h003, 12'h003, 1'b1, 1'b0);
    tbl[3] = mk(16'h0027, 12'h002, 12'h002, 12'h002, 12'h002, 12'h002, 1'b1, 1'b0);
    tbl[4] = mk(16'hFFF8, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 1'b1, 1'b0);
    tbl[5] = mk(16'hFFE8, 12'hFFE, 12'hFFF, 12'hFFE, 12'hFFE, 12'hFFF, 1'b1, 1'b0);
    tbl[6] = mk(16'h8008, 12'h800, 12'h801, 12'h800, 12'h800, 12'h801, 1'b1, 1'b0);
    tbl[7] = mk(16'h7FF7, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 1'b1, 1'b0);
    tbl[8] = mk(16'h0030, 12'h003, 12'h003, 12'h003, 12'h003, 12'h003, 1'b1, 1'b0);
    tbl[9] = mk(16'h0100, 12'h010, 12'h010, 12'h010, 12'h010, 12'h010, 1'b1, 1'b0);

    sat_w = mk(16'h7FF8, 12'h7FF, 12'h7FF, 12'h7FF, 12'h800, 12'h800, 1'b1, 1'b0);
    uns_w = tbl[4];
    a = mk(16'h0100, 12'h010, 12'h010, 12'h010, 12'h010, 12'h010, 1'b0, 1'b0);
    b = mk(16'h0208, 12'h020, 12'h021, 12'h020, 12'h020, 12'h021, 1'b0, 1'b1);
    c = mk(16'h0319, 12'h032, 12'h032, 12'h031, 12'h032, 12'h032, 1'b0, 1'b1);
    d = mk(16'h0417, 12'h041, 12'h041, 12'h041, 12'h041, 12'h041, 1'b0, 1'b1);

    // Reset state
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    checkOutput("rst_dout_valid", 64'(dout_valid_m2), 64'd0);
    checkOutput("rst_din_ready", 64'(din_ready_m2), 64'd1);
    checkOutput("rst_dout_data", 64'(dout_data_m2), 64'd0);
    checkOutput("rst_ovf_cnt", 64'(ovf_cnt_m2), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Table sweep, back-to-back with the output always ready
    $display("[TB] table sweep");
    for (int i = 0; i < 10; i++) applyStimulus(tbl[i]);
    din_valid = 1'b0;
    waitDrain("table_drain");

    // Saturation and counter
    $display("[TB] saturation and overflow counter");
    clearCounters();
    checkOutput("cnt_clear0", 64'(ovf_cnt_un), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(sat_w);
      exp_cnt = (i > 3) ? 3 : i;
      checkOutput("cnt_sat_m2", 64'(ovf_cnt_m2), 64'(exp_cnt));
      checkOutput("cnt_sat_wr", 64'(ovf_cnt_wr), 64'(exp_cnt));
    end
    din_valid = 1'b0;
    clearCounters();
    checkOutput("cnt_clr", 64'(ovf_cnt_m2), 64'd0);
    applyStimulus(sat_w);
    applyStimulus(sat_w);
    din_valid = 1'b0;
    checkOutput("cnt_pre", 64'(ovf_cnt_m2), 64'd2);
    ovf_clr = 1'b1;
    applyStimulus(sat_w);
    ovf_clr = 1'b0;
    din_valid = 1'b0;
    checkOutput("cnt_clr_ovf_m2", 64'(ovf_cnt_m2), 64'd1);
    checkOutput("cnt_clr_ovf_wr", 64'(ovf_cnt_wr), 64'd1);
    waitDrain("sat_drain");

    // Unsigned overflow
    clearCounters();
    applyStimulus(uns_w);
    din_valid = 1'b0;
    checkOutput("cnt_uns", 64'(ovf_cnt_un), 64'd1);
    checkOutput("cnt_signed_no_ovf", 64'(ovf_cnt_m2), 64'd0);
    waitDrain("uns_drain");

    // Backpressure: A, B fill main and skid, C and D wait
    $display("[TB] backpressure");
    dout_ready = 1'b0;
    applyStimulus(a);
    checkOutput("bp_ready_after_a", 64'(din_ready_m2), 64'd1);
    applyStimulus(b);
    checkOutput("bp_ready_after_b", 64'(din_ready_m2), 64'd0);
    checkOutput("bp_valid", 64'(dout_valid_m2), 64'd1);
    checkOutput("bp_hold1", 64'(dout_data_m2), 64'h010);
    cur_rec = c;
    din_data = c.din;
    @(posedge clk);
    #1;
    checkOutput("bp_hold2", 64'(dout_data_m2), 64'h010);
    checkOutput("bp_ready_held", 64'(din_ready_m2), 64'd0);
    dout_ready = 1'b1;
    applyStimulus(c);
    applyStimulus(d);
    din_valid = 1'b0;
    waitDrain("bp_drain");

    // Reset with main and skid both occupied
    $display("[TB] reset mid-stream");
    dout_ready = 1'b0;
    applyStimulus(a);
    applyStimulus(b);
    din_valid = 1'b0;
    checkOutput("pre_rst_ready", 64'(din_ready_m2), 64'd0);
    #2 rst = 1'b0;
    sb.delete();
    #1;
    checkOutput("async_rst_valid", 64'(dout_valid_m2), 64'd0);
    checkOutput("async_rst_ready", 64'(din_ready_m2), 64'd1);
    checkOutput("async_rst_data", 64'(dout_data_m2), 64'd0);
    checkOutput("async_rst_cnt", 64'(ovf_cnt_un), 64'd0);
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    rst = 1'b1;
    applyStimulus(tbl[8]);
    din_valid = 1'b0;
    waitDrain("post_rst_drain");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_stale_output", 64'(dout_valid_m2), 64'd0);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
